// File: rtl/half_stream_accumulate_pipe_pkg.sv
// half_pkg: shared FP16 types, FSM states and the round-to-nearest-even FP16 add.
package half_pkg;
  typedef logic [15:0] half_t;
  localparam half_t HALF_POS_ZERO = 16'h0000;
  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, REDUCE, OUT} state_t;
  function automatic half_t half_add(input half_t x, input half_t y);
    half_t hi, lo;
    logic [13:0] mh, ml, m;
    logic [14:0] s;
    logic [11:0] mr;
    logic sticky;
    int e, d;
    if (x[14:10] == 5'h1f || y[14:10] == 5'h1f) begin
      if ((x[14:10] == 5'h1f && x[9:0] != '0) || (y[14:10] == 5'h1f && y[9:0] != '0) ||
          (x[14:0] == 15'h7c00 && y[14:0] == 15'h7c00 && x[15] != y[15]))
        return 16'h7e00;
      return x[14:10] == 5'h1f ? x : y;
    end
    {hi, lo} = x[14:0] >= y[14:0] ? {x, y} : {y, x};
    e = hi[14:10] == '0 ? 1 : int'(hi[14:10]);
    d = e - (lo[14:10] == '0 ? 1 : int'(lo[14:10]));
    mh = {hi[14:10] != '0, hi[9:0], 3'b000};
    ml = {lo[14:10] != '0, lo[9:0], 3'b000};
    sticky = 1'b0;
    for (int i = 0; i < 14; i++)
      if (i < d) begin
        sticky = sticky | ml[0];
        ml = ml >> 1;
      end
    ml[0] = ml[0] | sticky;
    s = hi[15] == lo[15] ? {1'b0, mh} + {1'b0, ml} : {1'b0, mh} - {1'b0, ml};
    if (s == '0) return {hi[15] & lo[15], 15'h0000};
    if (s[14]) begin
      m = {s[14:2], |s[1:0]};
      e++;
    end else begin
      m = s[13:0];
      for (int i = 0; i < 13; i++)
        if (!m[13] && e > 1) begin
          m = m << 1;
          e--;
        end
    end
    mr = {1'b0, m[13:3]} + 12'(m[2] & (m[1] | m[0] | m[3]));
    if (mr[11]) begin
      mr = mr >> 1;
      e++;
    end
    if (e > 30) return {hi[15], 15'h7c00};
    return {hi[15], mr[10] ? e[4:0] : 5'd0, mr[9:0]};
  endfunction
endpackage

// File: rtl/half_stream_accumulate_pipe_if.sv
// half_stream_accumulate_pipe_if: element stream in, one FP16 sum per vector out.
interface half_stream_accumulate_pipe_if
  import half_pkg::*;
#(
  parameter int MAX_LEN = 64
);
  logic [$clog2(MAX_LEN + 1)-1:0] len;
  logic in_valid, in_ready, out_valid, out_ready;
  half_t a, c;
  modport master (output len, in_valid, a, out_ready, input in_ready, out_valid, c);
  modport slave (input len, in_valid, a, out_ready, output in_ready, out_valid, c);
endinterface

// File: rtl/half_stream_accumulate_pipe_add.sv
// half_add_pipe: non-stalling FP16 adder; its sum is captured by the consumer on the ADD_LAT-th edge after issue.
module half_add_pipe
  import half_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  half_t         x,
  input  half_t         y,
  input  logic [TW-1:0] tag_in,
  output logic          out_valid,
  output half_t         sum,
  output logic [TW-1:0] tag_out
);
  half_t s0;
  assign s0 = half_add(x, y);
  if (ADD_LAT == 1) begin : g_comb
    assign out_valid = in_valid;
    assign sum = s0;
    assign tag_out = tag_in;
  end else begin : g_pipe
    localparam int D = ADD_LAT - 1;
    logic [D-1:0] v_q;
    half_t s_q [D];
    logic [TW-1:0] t_q [D];
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) v_q <= '0;
      else v_q <= D'({v_q, in_valid});
    always_ff @(posedge clk) begin
      s_q[0] <= s0;
      t_q[0] <= tag_in;
      for (int i = 1; i < D; i++) begin
        s_q[i] <= s_q[i-1];
        t_q[i] <= t_q[i-1];
      end
    end
    assign out_valid = v_q[D-1];
    assign sum = s_q[D-1];
    assign tag_out = t_q[D-1];
  end
endmodule

// File: rtl/half_stream_accumulate_pipe.sv
// half_stream_accumulate_pipe: FP16 vector accumulator interleaving NSLOT partial sums
// over one pipelined adder, then folding them serially through the same adder.
module half_stream_accumulate_pipe
  import half_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MAX_LEN = 64
) (
  input logic clk,
  input logic rstn,
  half_stream_accumulate_pipe_if.slave s
);
  localparam int NSLOT = ADD_LAT + 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(NSLOT);
  localparam int TMW = $clog2(ADD_LAT) + 1;
  state_t state, nxt;
  logic [LW-1:0] l_q, cnt, len_eff;
  logic [SW-1:0] slot, k, tag, ptag;
  logic [TMW-1:0] tmr;
  half_t p [NSLOT];
  half_t acc, op_x, op_y, psum;
  logic beat, issue, pv, tmr_end;
  assign s.in_ready = state == IDLE || state == ACCUM;
  assign s.out_valid = state == OUT;
  assign s.c = state == OUT ? acc : HALF_POS_ZERO;
  assign beat = s.in_valid && (state == IDLE || state == ACCUM);
  assign tmr_end = tmr == TMW'(ADD_LAT - 1);
  assign len_eff = s.len == '0 || int'(s.len) > MAX_LEN ? LW'(MAX_LEN) : s.len;
  assign issue = beat || (state == REDUCE && tmr == '0);
  assign op_x = state == REDUCE ? acc : s.a;
  assign op_y = state == IDLE ? HALF_POS_ZERO : p[state == REDUCE ? k : slot];
  assign tag = state == IDLE ? '0 : slot;
  half_add_pipe #(.ADD_LAT(ADD_LAT), .TW(SW)) u_add (
    .clk(clk), .rstn(rstn), .in_valid(issue), .x(op_x), .y(op_y), .tag_in(tag),
    .out_valid(pv), .sum(psum), .tag_out(ptag)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (beat) nxt = len_eff == LW'(1) ? FLUSH : ACCUM;
      ACCUM:   if (beat && cnt == l_q - LW'(1)) nxt = FLUSH;
      FLUSH:   if (tmr_end) nxt = REDUCE;
      REDUCE:  if (tmr_end && k == SW'(NSLOT - 1)) nxt = OUT;
      OUT:     if (s.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      l_q <= '0;
      cnt <= '0;
      slot <= '0;
      k <= '0;
      tmr <= '0;
      acc <= HALF_POS_ZERO;
      for (int i = 0; i < NSLOT; i++) p[i] <= HALF_POS_ZERO;
    end else begin
      state <= nxt;
      tmr <= (state == FLUSH || state == REDUCE) && !tmr_end ? tmr + TMW'(1) : '0;
      if (state == IDLE && beat) begin
        l_q <= len_eff;
        cnt <= LW'(1);
        slot <= SW'(1);
        for (int i = 0; i < NSLOT; i++) p[i] <= HALF_POS_ZERO;
      end else if (state == ACCUM && beat) begin
        cnt <= cnt + LW'(1);
        slot <= slot == SW'(NSLOT - 1) ? '0 : slot + SW'(1);
      end
      // in-flight ACCUM results have all landed before REDUCE starts, so state alone routes write-back
      if (pv && state != REDUCE) p[ptag] <= psum;
      if (state == FLUSH && tmr_end) begin
        acc <= p[0];
        k <= SW'(1);
      end
      if (state == REDUCE && tmr_end) k <= k + SW'(1);
      if (pv && state == REDUCE) acc <= psum;
    end
endmodule

// File: tb/tb_half_stream_accumulate_pipe.sv
// tb_half_stream_accumulate_pipe: directed and randomized checks of the FP16 stream accumulator.
module tb_half_stream_accumulate_pipe;
  import half_pkg::*;
  localparam int ADD_LAT = 2;
  localparam int MAX_LEN = 64;
  localparam int NSLOT = ADD_LAT + 1;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int vectors = 0;
  int errs = 0;
  half_t q[$];
  half_stream_accumulate_pipe_if #(.MAX_LEN(MAX_LEN)) bus ();
  half_stream_accumulate_pipe #(.ADD_LAT(ADD_LAT), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rstn(rstn), .s(bus)
  );
  always #5 clk = ~clk;

  function automatic half_t int2half(input int n);
    int m, e;
    if (n == 0) return 16'h0000;
    m = n < 0 ? -n : n;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return {n < 0, 5'(e + 15), 10'((m << (10 - e)) & 'h3ff)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int ln, input int gap_pct, output bit ok);
    int i, tries;
    bit v, rdy;
    i = 0;
    tries = 0;
    ok = 1'b1;
    while (i < q.size()) begin
      v = $urandom_range(99) >= gap_pct;
      bus.in_valid = v;
      bus.a = v ? q[i] : half_t'($urandom);
      bus.len = i == 0 ? 7'(ln) : 7'($urandom);
      rdy = bus.in_ready;
      tick();
      if (v && rdy) i++;
      tries++;
      if (tries > 4000) begin
        ok = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      errs++;
      $display("FAIL send_timeout accepted=%0d required=%0d", i, q.size());
    end
  endtask

  task automatic wait_out(output int n, output half_t got);
    n = 0;
    while (!bus.out_valid && n < 400) begin
      tick();
      n++;
    end
    got = bus.c;
    if (!bus.out_valid) begin
      vectors++;
      errs++;
      $display("FAIL out_timeout waited=%0d cycles", n);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.len = '0;
    rstn = 1'b0;
    repeat (3) tick();
    vectors += 3;
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    if (bus.c !== 16'h0000) begin errs++; $display("FAIL reset_c got=%h want=0000", bus.c); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int n;
    half_t got;
    bit ok;
    q = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    bus.out_ready = 1'b1;
    send_vec(4, 0, ok);
    wait_out(n, got);
    vectors += 2;
    if (got !== 16'h4400) begin errs++; $display("FAIL latency_sum got=%h want=4400", got); end
    if (n != NSLOT * ADD_LAT) begin errs++; $display("FAIL latency_cycles got=%0d want=%0d", n + 1, NSLOT * ADD_LAT + 1); end
    tick();
  endtask

  task automatic test_gaps();
    int n, pulses;
    half_t got;
    bit ok;
    q = {};
    repeat (10) q.push_back(16'h3C00);
    bus.out_ready = 1'b1;
    send_vec(10, 40, ok);
    wait_out(n, got);
    vectors++;
    if (got !== 16'h4900) begin errs++; $display("FAIL gaps_sum got=%h want=4900", got); end
    tick();
    pulses = 0;
    repeat (20) begin
      pulses += int'(bus.out_valid);
      tick();
    end
    vectors++;
    if (pulses != 0) begin errs++; $display("FAIL gaps_extra_pulses got=%0d want=0", pulses); end
  endtask

  task automatic test_len1();
    int n;
    half_t got;
    bit ok;
    bus.out_ready = 1'b1;
    q = {16'hC000};
    send_vec(1, 0, ok);
    wait_out(n, got);
    vectors++;
    if (got !== 16'hC000) begin errs++; $display("FAIL len1_neg got=%h want=C000", got); end
    tick();
    q = {16'h8000};
    send_vec(1, 0, ok);
    wait_out(n, got);
    vectors++;
    if (got !== 16'h0000) begin errs++; $display("FAIL len1_negzero got=%h want=0000", got); end
    tick();
  endtask

  task automatic test_hold();
    int n;
    half_t got;
    bit ok;
    bus.out_ready = 1'b0;
    q = {16'h3C00, 16'h4000};
    send_vec(2, 0, ok);
    wait_out(n, got);
    repeat (5) begin
      tick();
      vectors += 3;
      if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL hold_out_valid got=%b want=1", bus.out_valid); end
      if (bus.c !== 16'h4200) begin errs++; $display("FAIL hold_c got=%h want=4200", bus.c); end
      if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL hold_in_ready got=%b want=0", bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL next_vec_ready got=%b want=1", bus.in_ready); end
    q = {16'h4000, 16'h4000};
    send_vec(2, 0, ok);
    wait_out(n, got);
    vectors++;
    if (got !== 16'h4400) begin errs++; $display("FAIL next_vec_sum got=%h want=4400", got); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n, seen;
    half_t got;
    bit ok;
    bus.out_ready = 1'b1;
    q = {16'h3C00, 16'h3C00, 16'h3C00};
    send_vec(8, 0, ok);
    rstn = 1'b0;
    #1;
    vectors += 2;
    if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
    tick();
    rstn = 1'b1;
    seen = 0;
    repeat (20) begin
      seen += int'(bus.out_valid);
      tick();
    end
    vectors++;
    if (seen != 0) begin errs++; $display("FAIL midrst_stale_output got=%0d want=0", seen); end
    q = {16'h3C00, 16'h3C00};
    send_vec(2, 0, ok);
    wait_out(n, got);
    vectors++;
    if (got !== 16'h4000) begin errs++; $display("FAIL midrst_next_sum got=%h want=4000", got); end
    tick();
  endtask

  task automatic test_maxlen();
    int n;
    half_t got;
    bit ok;
    int lens[2];
    lens = '{0, MAX_LEN + 1};
    bus.out_ready = 1'b1;
    foreach (lens[j]) begin
      q = {};
      repeat (MAX_LEN) q.push_back(16'h3C00);
      send_vec(lens[j], 10, ok);
      wait_out(n, got);
      vectors++;
      if (got !== 16'h5400) begin errs++; $display("FAIL maxlen_len%0d got=%h want=5400", lens[j], got); end
      tick();
    end
  endtask

  task automatic test_random();
    int n, ln, sum, v, hold;
    half_t got, want;
    bit ok;
    repeat (10) begin
      ln = $urandom_range(20, 1);
      sum = 0;
      q = {};
      for (int i = 0; i < ln; i++) begin
        v = int'($urandom_range(32)) - 16;
        sum += v;
        q.push_back(int2half(v));
      end
      want = int2half(sum);
      bus.out_ready = 1'b0;
      send_vec(ln, 30, ok);
      wait_out(n, got);
      vectors++;
      if (got !== want) begin errs++; $display("FAIL random_len%0d got=%h want=%h", ln, got, want); end
      hold = $urandom_range(3);
      repeat (hold) begin
        tick();
        vectors++;
        if (bus.c !== want) begin errs++; $display("FAIL random_hold got=%h want=%h", bus.c, want); end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_gaps();
    test_len1();
    test_hold();
    test_reset_mid();
    test_maxlen();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
